// File: rtl/oscillator_phase_gen.sv
// Per-voice phase accumulator feeding the sine shaper.
// Frequency changes and note-off only land on half-cycle wraps.
module oscillator_phase_gen #(
    // Default width of a long_percent_t position.
    parameter int PHASE_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   sample_tick,
    input  logic                   note_on,
    input  logic [PHASE_WIDTH-1:0] increment,
    output logic                   state,
    output logic [PHASE_WIDTH-1:0] phase,
    output logic                   sample_valid,
    output logic                   active
);

    localparam logic FRONT = 1'b0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUNNING  = 2'd1,
        STOPPING = 2'd2
    } fsm_t;

    fsm_t                   fsm;
    logic [PHASE_WIDTH-1:0] cur_inc;
    logic [PHASE_WIDTH-1:0] pend_inc;
    logic [PHASE_WIDTH:0]   sum;
    logic                   carry;

    assign sum   = {1'b0, phase} + {1'b0, cur_inc};
    assign carry = sum[PHASE_WIDTH];

    always_ff @(posedge clock) begin
        if (reset) begin
            fsm          <= IDLE;
            state        <= FRONT;
            phase        <= '0;
            cur_inc      <= '0;
            pend_inc     <= '0;
            sample_valid <= 1'b0;
            active       <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (note_on) begin
                pend_inc <= increment;
            end
            unique case (fsm)
                IDLE: begin
                    // Entry wins over a coincident tick.
                    if (note_on) begin
                        fsm     <= RUNNING;
                        cur_inc <= increment;
                        state   <= FRONT;
                        phase   <= '0;
                        active  <= 1'b1;
                    end
                end
                RUNNING: begin
                    if (sample_tick) begin
                        sample_valid <= 1'b1;
                        phase        <= sum[PHASE_WIDTH-1:0];
                        if (carry) begin
                            state   <= ~state;
                            cur_inc <= pend_inc;
                        end
                    end
                    if (!note_on) begin
                        fsm <= STOPPING;
                    end
                end
                STOPPING: begin
                    if (sample_tick && carry) begin
                        sample_valid <= 1'b1;
                        state        <= FRONT;
                        phase        <= '0;
                        active       <= 1'b0;
                        fsm          <= IDLE;
                    end else begin
                        if (sample_tick) begin
                            sample_valid <= 1'b1;
                            phase        <= sum[PHASE_WIDTH-1:0];
                        end
                        if (note_on) begin
                            fsm <= RUNNING;
                        end
                    end
                end
                default: begin
                    fsm    <= IDLE;
                    state  <= FRONT;
                    phase  <= '0;
                    active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/oscillator_phase_gen.md
# oscillator_phase_gen

Sequential phase generator that produces the `(state, phase)` pair consumed by the `Sine` shaper: an `OSCILLATOR::oscillator_state_t` half-cycle indicator plus a `CONFIG::long_percent_t` position within that half.
- Once per audio sample tick it advances phase by a per-voice increment and toggles FRONT/BACK on each half-cycle wrap.
- Frequency changes and note-off take effect only at zero crossings (half-cycle boundaries), so the waveform never clicks.
- One instance sits per voice, between the MIDI/voice allocator and the waveform shaper.

## Interface
Parameters:
- PHASE_WIDTH, default `$bits(CONFIG::long_percent_t)`: width of phase and increment.

Ports (one clock; reset is synchronous and active-high):
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- sample_tick  in  1  one-cycle pulse at the audio sample rate
- note_on  in  1  level; high = voice gated on
- increment  in  PHASE_WIDTH  phase step per sample tick (unsigned)
- state  out  oscillator_state_t  FRONT/BACK half-cycle
- phase  out  PHASE_WIDTH  position within the current half-cycle
- sample_valid  out  1  one-cycle pulse: state/phase were updated this cycle
- active  out  1  high while in RUNNING or STOPPING

## Operation
- FSM states:
  - IDLE: outputs parked at state=FRONT, phase=0.
  - RUNNING: phase advances on each tick.
  - STOPPING: note released; the current half-cycle is finished before returning to IDLE.
- Registered copies:
  - `cur_inc`: the increment in use.
  - `pend_inc`: the increment latched from the `increment` input on every clock while note_on=1.
- IDLE → RUNNING:
  - Taken on the first clock with note_on=1.
  - On entry, cur_inc ← increment, state=FRONT, phase=0.
  - No phase advance on the entry cycle.
- RUNNING, on sample_tick:
  - Form the sum {1'b0,phase} + {1'b0,cur_inc} at PHASE_WIDTH+1 bits.
  - phase ← sum[PHASE_WIDTH-1:0].
  - If the carry sum[PHASE_WIDTH]=1, state toggles (FRONT↔BACK) and cur_inc ← pend_inc. This is the zero crossing.
  - A single tick toggles state at most once; increment < 2^PHASE_WIDTH guarantees this.
- RUNNING → STOPPING: note_on=0 on any clock. pend_inc is frozen from then on.
- STOPPING:
  - Keeps advancing on ticks with cur_inc.
  - On the tick that produces a carry: state ← FRONT, phase ← 0, go to IDLE. No toggle to the next half.
- STOPPING → RUNNING: note_on returning to 1 before the carry resumes RUNNING with no phase discontinuity; pend_inc latching resumes.
- increment=0 while RUNNING: phase holds, sample_valid still pulses on ticks. A STOPPING voice with cur_inc=0 stays in STOPPING until note_on returns or reset.
- sample_valid:
  - Pulses on every tick processed in RUNNING or STOPPING, including the tick that enters IDLE.
  - Never pulses in IDLE.
- active: 1 in RUNNING/STOPPING, 0 in IDLE.

## Timing
- All outputs are registered.
- A sample_tick sampled at edge N updates state/phase/sample_valid visibly after edge N: one-cycle latency.
- Simultaneous events:
  - note_on rise and sample_tick in IDLE on the same clock: the entry takes priority and the tick is ignored (no advance, no sample_valid).
  - note_on fall and sample_tick on the same clock in RUNNING: the tick is processed as RUNNING (toggle allowed if it carries); the FSM is in STOPPING afterwards.
- increment changes mid-half: no effect until the next carry. The value used is the last one latched while note_on=1.
- Reset (any time, including mid-half or STOPPING) forces the following on the next edge; it overrides all inputs:
  - FSM=IDLE, state=FRONT, phase=0
  - cur_inc=0, pend_inc=0
  - sample_valid=0, active=0
- sample_tick asserted on consecutive clocks: each one is processed. No minimum spacing.

## Test plan
Bench uses PHASE_WIDTH=8.
1. Reset, then note_on=1 with increment=64, then 4 ticks:
   - phase 64,128,192,0 with state FRONT,FRONT,FRONT,BACK.
   - sample_valid pulses once per tick, one cycle after each tick.
2. Running at increment=64 with phase=128 FRONT, change increment to 100:
   - Ticks give phase 192 FRONT, then 0 BACK (carry uses 64).
   - The next tick gives 100 BACK.
3. Running at increment=64 with phase=64 BACK, drop note_on:
   - Ticks give 128,192, then phase=0 FRONT with active→0.
   - Further ticks produce no sample_valid.
4. STOPPING at phase=128 BACK, raise note_on before the carry:
   - The next ticks give 192 BACK, then 0 FRONT (a toggle, not a stop); active stays 1.
5. increment=200 from phase=100 FRONT:
   - One tick gives phase=44, state BACK (single toggle, wrap arithmetic).
6. Assert reset mid-STOPPING at phase=192 BACK:
   - Next edge gives state=FRONT, phase=0, active=0, sample_valid=0.
   - A same-cycle tick is ignored.
